// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 0011 serial pattern detector.
package seq_det_pkg;

    // Each state names the longest prefix of the pattern matched so far.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S0    = 3'd1,
        S00   = 3'd2,
        S001  = 3'd3,
        S0011 = 3'd4
    } seq_state_t;

    // The fixed marker, oldest bit in the MSB, for documentation and benches.
    localparam logic [3:0] PATTERN = 4'b0011;

endpackage

// File: rtl/seq_detector_0011.sv
// Moore FSM that flags a completed 0,0,1,1 on a one-bit-per-clock serial stream.
// The flag is decoded from the state register only, so data_in never reaches
// detected combinationally.
module seq_detector_0011
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic data_in,
    output logic detected
);

    seq_state_t state;
    seq_state_t next_state;

    // State register; reset drops any partial match immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode; unused encodings fall back to IDLE.
    always_comb begin
        next_state = IDLE;
        detected   = 1'b0;
        unique case (state)
            IDLE: begin
                next_state = data_in ? IDLE : S0;
            end
            S0: begin
                next_state = data_in ? IDLE : S00;
            end
            S00: begin
                next_state = data_in ? S001 : S00;
            end
            S001: begin
                next_state = data_in ? S0011 : S0;
            end
            S0011: begin
                detected   = 1'b1;
                next_state = data_in ? IDLE : S0;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_detector_0011.sv
// Self-checking bench for seq_detector_0011 using a bit-history reference model.
module tb_seq_detector_0011;
    import seq_det_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic data_in;
    logic detected;

    int checks   = 0;
    int failures = 0;

    // Reference model: the last four bits seen since reset and how many there were.
    logic [3:0] hist;
    int         seen;

    always #5 clk = ~clk;

    seq_detector_0011 dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .detected (detected)
    );

    function automatic logic model_expect();
        return (seen >= 4) && (hist == PATTERN);
    endfunction

    task automatic model_clear();
        hist = 4'b0;
        seen = 0;
    endtask

    task automatic model_push(input logic b);
        hist = {hist[2:0], b};
        seen = seen + 1;
    endtask

    // Drive one bit on the falling edge, then look just after the rising edge.
    task automatic drive_bit(input logic b);
        @(negedge clk);
        data_in = b;
        @(posedge clk);
        #1;
        model_push(b);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset   = 1'b1;
        data_in = 1'bx;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset   = 1'b0;
        data_in = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        data_in = 1'bx;
        model_clear();
        #1;
        checks++;
        if (detected !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got=%b want=0", detected);
        end
        @(posedge clk);
        #1;
        checks++;
        if (detected !== 1'b0) begin
            failures++;
            $display("FAIL reset_held got=%b want=0", detected);
        end
        @(negedge clk);
        reset   = 1'b0;
        data_in = 1'b1;
        @(posedge clk);
        #1;
        model_push(1'b1);
        checks++;
        if (detected !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_sample got=%b want=0", detected);
        end
    endtask

    task automatic test_main_stream();
        logic [15:0] stim;
        logic [15:0] want_vec;
        stim     = 16'b0001100110110010;
        want_vec = 16'b0000010001000000;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            drive_bit(stim[15-i]);
            checks++;
            if (detected !== model_expect()) begin
                failures++;
                $display("FAIL main_model bit=%0d got=%b want=%b", i, detected, model_expect());
            end
            if (i < 15) begin
                checks++;
                if (detected !== want_vec[14-i]) begin
                    failures++;
                    $display("FAIL main_vector bit=%0d got=%b want=%b", i, detected, want_vec[14-i]);
                end
            end
        end
    endtask

    task automatic test_trailing_one();
        logic [8:0] stim;
        int pulses;
        stim   = 9'b001110011;
        pulses = 0;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive_bit(stim[8-i]);
            if (detected === 1'b1) pulses++;
            checks++;
            if (detected !== model_expect()) begin
                failures++;
                $display("FAIL trailing_model bit=%0d got=%b want=%b", i, detected, model_expect());
            end
        end
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL trailing_pulses got=%0d want=2", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stim;
        int first_hit;
        int second_hit;
        int pulses;
        stim       = 8'b00110011;
        first_hit  = -1;
        second_hit = -1;
        pulses     = 0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive_bit(stim[7-i]);
            if (detected === 1'b1) begin
                pulses++;
                if (first_hit < 0) first_hit = i;
                else second_hit = i;
            end
        end
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL b2b_pulses got=%0d want=2", pulses);
        end
        checks++;
        if ((second_hit - first_hit) != 4) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d want=4", second_hit - first_hit);
        end
    endtask

    task automatic test_near_miss();
        logic [3:0] pats [3];
        pats[0] = 4'b0101;
        pats[1] = 4'b1100;
        pats[2] = 4'b0010;
        for (int p = 0; p < 3; p++) begin
            apply_reset();
            for (int i = 0; i < 4; i++) begin
                drive_bit(pats[p][3-i]);
                checks++;
                if (detected !== 1'b0) begin
                    failures++;
                    $display("FAIL near_miss pat=%b bit=%0d got=%b want=0", pats[p], i, detected);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        #2;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_clear();
        drive_bit(1'b1);
        checks++;
        if (detected !== 1'b0) begin
            failures++;
            $display("FAIL async_partial got=%b want=0", detected);
        end
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        checks++;
        if (detected !== 1'b1) begin
            failures++;
            $display("FAIL async_fresh_match got=%b want=1", detected);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (detected !== 1'b0) begin
            failures++;
            $display("FAIL async_clear_pulse got=%b want=0", detected);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_random();
        logic b;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            b = 1'($urandom_range(0, 1));
            drive_bit(b);
            checks++;
            if (detected !== model_expect()) begin
                failures++;
                $display("FAIL random bit=%0d got=%b want=%b", i, detected, model_expect());
            end
        end
    endtask

    // Run every scenario in order and report one summary line.
    initial begin
        test_reset();
        test_main_stream();
        test_trailing_one();
        test_back_to_back();
        test_near_miss();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
